// File: rtl/sdram_mport_arb.sv
// rtl/sdram_mport_arb.sv - round-robin multi-port front end for sdram_top with in-order read tag routing
// Optional feature macro: SDRAM_ARB_HOLD_EN keeps a grant for up to HOLD_MAX back-to-back beats.
module sdram_mport_arb #(
  parameter int NPORT     = 4,
  parameter int DW        = 16,
  parameter int AW        = 22,
  parameter int TAG_DEPTH = 8,
  parameter int HOLD_MAX  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sdram_init_done,
  input  logic [NPORT*DW-1:0] p_wr_data,
  input  logic [NPORT*AW-1:0] p_wr_addr,
  input  logic [NPORT-1:0]    p_wr_valid,
  output logic [NPORT-1:0]    p_wr_ready,
  input  logic [NPORT*AW-1:0] p_rd_addr,
  input  logic [NPORT-1:0]    p_rd_avalid,
  output logic [NPORT-1:0]    p_rd_aready,
  output logic [NPORT*DW-1:0] p_rd_data,
  output logic [NPORT-1:0]    p_rd_valid,
  input  logic [NPORT-1:0]    p_rd_ready,
  output logic [DW-1:0]       m_wr_data,
  output logic [AW-1:0]       m_wr_addr,
  output logic                m_wr_valid,
  input  logic                m_wr_ready,
  output logic [AW-1:0]       m_rd_addr,
  output logic                m_rd_avalid,
  input  logic                m_rd_aready,
  input  logic [DW-1:0]       m_rd_data,
  input  logic                m_rd_valid,
  output logic                m_rd_ready,
  output logic                rd_tag_err
);
  localparam int TW = $clog2(NPORT);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

  state_t        state, state_d;
  logic [TW-1:0] last, last_d, gnt_idx, gnt_idx_d, arb_idx;
  logic          gnt_wr, gnt_wr_d, arb_found;
  logic [NPORT-1:0] req;

  logic [TW-1:0] tag_mem [TAG_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] tag_cnt, tag_cnt_nxt;
  logic          tag_full, tag_empty, push, pop, wr_hs, rd_hs, xfer;
  logic [TW-1:0] tag_head;

`ifdef SDRAM_ARB_HOLD_EN
  localparam int BW = $clog2(HOLD_MAX + 1);
  logic [BW-1:0] beat_cnt, beat_cnt_d;
  logic          hold_ok;
`endif

  assign tag_full  = (tag_cnt == CW'(TAG_DEPTH));
  assign tag_empty = (tag_cnt == '0);
  assign tag_head  = tag_mem[rptr];
  assign xfer      = (state == XFER);

  // Master side is a pure mux of the registered grant; idle outputs are forced to zero.
  assign m_wr_valid  = xfer & gnt_wr & p_wr_valid[gnt_idx];
  assign m_rd_avalid = xfer & ~gnt_wr & p_rd_avalid[gnt_idx];
  assign m_wr_data   = (xfer & gnt_wr) ? p_wr_data[int'(gnt_idx)*DW +: DW] : '0;
  assign m_wr_addr   = (xfer & gnt_wr) ? p_wr_addr[int'(gnt_idx)*AW +: AW] : '0;
  assign m_rd_addr   = (xfer & ~gnt_wr) ? p_rd_addr[int'(gnt_idx)*AW +: AW] : '0;

  assign wr_hs = m_wr_valid & m_wr_ready;
  assign rd_hs = m_rd_avalid & m_rd_aready;
  assign push  = rd_hs;
  assign pop   = m_rd_valid & m_rd_ready & ~tag_empty;
  assign tag_cnt_nxt = tag_cnt + CW'(push) - CW'(pop);

  always_comb begin
    p_wr_ready  = '0;
    p_rd_aready = '0;
    if (xfer && gnt_wr)  p_wr_ready[gnt_idx]  = m_wr_ready;
    if (xfer && !gnt_wr) p_rd_aready[gnt_idx] = m_rd_aready;
  end

  // Return path: the FIFO head selects the client; an empty FIFO drains stray data.
  assign p_rd_data = {NPORT{m_rd_data}};
  always_comb begin
    p_rd_valid = '0;
    m_rd_ready = 1'b1;
    if (!tag_empty) begin
      p_rd_valid[tag_head] = m_rd_valid;
      m_rd_ready           = p_rd_ready[tag_head];
    end
  end

  always_comb begin
    for (int k = 0; k < NPORT; k++) req[k] = p_wr_valid[k] | (p_rd_avalid[k] & ~tag_full);
  end

  always_comb begin
    int c;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 1; i <= NPORT; i++) begin
      c = (int'(last) + i) % NPORT;
      if (!arb_found && req[c]) begin
        arb_found = 1'b1;
        arb_idx   = TW'(c);
      end
    end
  end

`ifdef SDRAM_ARB_HOLD_EN
  assign hold_ok = (int'(beat_cnt) < HOLD_MAX - 1) &&
                   (gnt_wr ? p_wr_valid[gnt_idx]
                           : (p_rd_avalid[gnt_idx] && (tag_cnt_nxt != CW'(TAG_DEPTH))));
`endif

  always_comb begin
    state_d   = state;
    last_d    = last;
    gnt_idx_d = gnt_idx;
    gnt_wr_d  = gnt_wr;
`ifdef SDRAM_ARB_HOLD_EN
    beat_cnt_d = beat_cnt;
`endif
    case (state)
      IDLE: if (sdram_init_done) state_d = ARB;
      ARB: begin
        if (arb_found) begin
          state_d   = XFER;
          gnt_idx_d = arb_idx;
          gnt_wr_d  = p_wr_valid[arb_idx];
`ifdef SDRAM_ARB_HOLD_EN
          beat_cnt_d = '0;
`endif
        end
      end
      XFER: begin
        if (wr_hs || rd_hs) begin
          last_d  = gnt_idx;
          state_d = ARB;
`ifdef SDRAM_ARB_HOLD_EN
          if (hold_ok) begin
            state_d    = XFER;
            beat_cnt_d = beat_cnt + BW'(1);
          end
`endif
        end else if (gnt_wr ? !p_wr_valid[gnt_idx] : !p_rd_avalid[gnt_idx]) begin
          state_d = ARB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= TW'(NPORT - 1);
      gnt_idx <= '0;
      gnt_wr  <= 1'b0;
    end else begin
      state   <= state_d;
      last    <= last_d;
      gnt_idx <= gnt_idx_d;
      gnt_wr  <= gnt_wr_d;
    end
  end

`ifdef SDRAM_ARB_HOLD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_cnt <= '0;
    else        beat_cnt <= beat_cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      tag_cnt    <= '0;
      rd_tag_err <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      tag_cnt <= tag_cnt_nxt;
      if (m_rd_valid && tag_empty) rd_tag_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wptr] <= gnt_idx;
  end

endmodule

// File: tb/tb_sdram_mport_arb.sv
// tb/tb_sdram_mport_arb.sv - self-checking bench for sdram_mport_arb: directed scenarios plus random traffic vs a queue model
module tb_sdram_mport_arb;
  localparam int NPORT = 4, DW = 16, AW = 22, TAG_DEPTH = 8, HOLD_MAX = 4;
`ifdef SDRAM_ARB_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sdram_init_done;
  logic [NPORT*DW-1:0] p_wr_data, p_rd_data;
  logic [NPORT*AW-1:0] p_wr_addr, p_rd_addr;
  logic [NPORT-1:0] p_wr_valid, p_wr_ready, p_rd_avalid, p_rd_aready, p_rd_valid, p_rd_ready;
  logic [DW-1:0] m_wr_data, m_rd_data;
  logic [AW-1:0] m_wr_addr, m_rd_addr;
  logic m_wr_valid, m_wr_ready, m_rd_avalid, m_rd_aready, m_rd_valid, m_rd_ready, rd_tag_err;

  sdram_mport_arb #(.NPORT(NPORT), .DW(DW), .AW(AW), .TAG_DEPTH(TAG_DEPTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
    .p_wr_data(p_wr_data), .p_wr_addr(p_wr_addr), .p_wr_valid(p_wr_valid), .p_wr_ready(p_wr_ready),
    .p_rd_addr(p_rd_addr), .p_rd_avalid(p_rd_avalid), .p_rd_aready(p_rd_aready),
    .p_rd_data(p_rd_data), .p_rd_valid(p_rd_valid), .p_rd_ready(p_rd_ready),
    .m_wr_data(m_wr_data), .m_wr_addr(m_wr_addr), .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready),
    .m_rd_addr(m_rd_addr), .m_rd_avalid(m_rd_avalid), .m_rd_aready(m_rd_aready),
    .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .rd_tag_err(rd_tag_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    p_wr_data = '0; p_wr_addr = '0; p_wr_valid = '0;
    p_rd_addr = '0; p_rd_avalid = '0; p_rd_ready = '1;
    m_wr_ready = 1'b0; m_rd_aready = 1'b0; m_rd_data = '0; m_rd_valid = 1'b0;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    settle;
    step;
    rst_n = 1'b1;
  endtask

  function automatic int oh_idx(input logic [NPORT-1:0] v);
    int r = -1;
    int n = 0;
    for (int i = 0; i < NPORT; i++) if (v[i]) begin r = i; n++; end
    return (n == 1) ? r : -1;
  endfunction

  // Controller memory contents as seen by the bench: any fixed address-to-data mapping works.
  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a * 7 + 13;
    return t[DW-1:0] ^ 16'h5A5A;
  endfunction

  task automatic do_read(input int k, input logic [AW-1:0] a, input string tag);
    bit done = 1'b0;
    p_rd_addr[k*AW +: AW] = a;
    p_rd_avalid[k] = 1'b1;
    m_rd_aready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      settle;
      if (m_rd_avalid && m_rd_aready && p_rd_aready[k]) begin
        check({tag, "_addr"}, m_rd_addr, a);
        done = 1'b1;
      end
      step;
    end
    p_rd_avalid[k] = 1'b0;
    check({tag, "_done"}, done, 1);
  endtask

  task automatic expect_return(input int k, input logic [DW-1:0] d, input string tag);
    m_rd_valid = 1'b1;
    m_rd_data  = d;
    settle;
    check({tag, "_valid"}, p_rd_valid, NPORT'(1) << k);
    check({tag, "_data"}, p_rd_data[k*DW +: DW], d);
    check({tag, "_ready"}, m_rd_ready, p_rd_ready[k]);
    step;
    m_rd_valid = 1'b0;
  endtask

  int wcnt [NPORT];

  task automatic drive_rr;
    for (int k = 0; k < NPORT; k++) begin
      p_wr_valid[k] = 1'b1;
      p_wr_addr[k*AW +: AW] = AW'(k * 256 + wcnt[k]);
      p_wr_data[k*DW +: DW] = DW'(k * 4096 + wcnt[k]);
    end
  endtask

  // Random-phase model state
  bit               wpend [NPORT], rpend [NPORT];
  logic [AW-1:0]    waddr [NPORT], raddr [NPORT];
  logic [DW-1:0]    wdata [NPORT];
  logic [DW-1:0]    exp_q [NPORT][$];
  int               tagq [$];
  logic [DW-1:0]    ctrl_q [$];

  initial begin
    int beats, last_c, exp_k, k, ref_last, last_hs_c;
    bit flag, flag2, ctrl_valid, hs_w, hs_r, unfair, busy;
    logic [NPORT-1:0] pset, wset, exp_prv;
    int full_ports [8];
    int drain_ports [8];
    full_ports  = '{1, 0, 2, 3, 1, 0, 2, 3};
    drain_ports = '{0, 2, 3, 1, 0, 2, 3, 1};

    // Reset: outputs idle even with busy inputs.
    sdram_init_done = 1'b0;
    clear_inputs;
    p_wr_data = '1; p_wr_addr = '1; p_wr_valid = '1; p_rd_avalid = '1; p_rd_addr = '1;
    m_wr_ready = 1'b1; m_rd_aready = 1'b1;
    #1 rst_n = 1'b0;
    step;
    settle;
    check("rst_m_wr_valid", m_wr_valid, 0);
    check("rst_m_rd_avalid", m_rd_avalid, 0);
    check("rst_p_wr_ready", p_wr_ready, 0);
    check("rst_p_rd_aready", p_rd_aready, 0);
    check("rst_p_rd_valid", p_rd_valid, 0);
    check("rst_m_rd_ready", m_rd_ready, 1);
    check("rst_rd_tag_err", rd_tag_err, 0);
    check("rst_m_wr_data", m_wr_data, 0);
    check("rst_m_wr_addr", m_wr_addr, 0);
    check("rst_m_rd_addr", m_rd_addr, 0);
    clear_inputs;
    step;
    rst_n = 1'b1;

    // Init gating
    p_wr_addr[0 +: AW] = 22'h000010;
    p_wr_data[0 +: DW] = 16'hA5A5;
    p_wr_valid[0] = 1'b1;
    m_wr_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle;
      check("init_gate", m_wr_valid, 0);
      step;
    end
    sdram_init_done = 1'b1;
    settle;
    check("init_n0", m_wr_valid, 0);
    step;
    settle;
    check("init_n1", m_wr_valid, 0);
    step;
    settle;
    check("init_n2_valid", m_wr_valid, 1);
    check("init_n2_addr", m_wr_addr, 22'h000010);
    check("init_n2_data", m_wr_data, 16'hA5A5);
    check("init_n2_ready", p_wr_ready, 4'b0001);
    step;
    p_wr_valid = '0;

    // Round-robin from a fresh reset: port 0 has first priority.
    pulse_reset;
    for (int i = 0; i < NPORT; i++) wcnt[i] = 0;
    drive_rr;
    m_wr_ready = 1'b1;
    beats = 0;
    last_c = 0;
    for (int c = 0; c < 60 && beats < 8; c++) begin
      settle;
      if (m_wr_valid && m_wr_ready) begin
        exp_k = HOLD ? (beats / HOLD_MAX) % NPORT : beats % NPORT;
        check("rr_port", p_wr_ready, NPORT'(1) << exp_k);
        check("rr_data", m_wr_data, DW'(exp_k * 4096 + wcnt[exp_k]));
        check("rr_addr", m_wr_addr, AW'(exp_k * 256 + wcnt[exp_k]));
        if (beats > 0) check("rr_gap", c - last_c, (HOLD && (beats % HOLD_MAX != 0)) ? 1 : 2);
        last_c = c;
        beats++;
        k = oh_idx(p_wr_ready);
        wcnt[(k >= 0) ? k : exp_k]++;
      end
      step;
      drive_rr;
    end
    check("rr_beats", beats, 8);
    p_wr_valid = '0;
    m_wr_ready = 1'b0;
    step;

    // Read routing
    do_read(2, 22'h000200, "rt_a2");
    do_read(0, 22'h000000, "rt_a0");
    do_read(3, 22'h000300, "rt_a3");
    p_rd_ready = '1;
    expect_return(2, 16'h1111, "rt_r2");
    expect_return(0, 16'h2222, "rt_r0");
    expect_return(3, 16'h3333, "rt_r3");

    // Tag FIFO full: reads stall, writes still go through.
    for (int i = 0; i < 8; i++) do_read(full_ports[i], AW'(22'h000300 + i), "full_fill");
    p_rd_ready = '0;
    p_rd_addr[1*AW +: AW] = 22'h0003FF;
    p_rd_avalid[1] = 1'b1;
    p_wr_addr[3*AW +: AW] = 22'h0003AA;
    p_wr_data[3*DW +: DW] = 16'hBEEF;
    p_wr_valid[3] = 1'b1;
    m_wr_ready = 1'b1;
    m_rd_aready = 1'b1;
    flag = 1'b0;
    flag2 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      settle;
      if (p_rd_aready[1] || m_rd_avalid) flag = 1'b1;
      if (m_wr_valid && p_wr_ready[3]) begin
        flag2 = 1'b1;
        check("full_wr_data", m_wr_data, 16'hBEEF);
      end
      step;
      if (flag2) p_wr_valid[3] = 1'b0;
    end
    check("full_rd_stall", flag, 0);
    check("full_wr_granted", flag2, 1);

    // Backpressure on head port 1
    m_rd_valid = 1'b1;
    m_rd_data = 16'h4444;
    for (int c = 0; c < 5; c++) begin
      settle;
      check("bp_m_rd_ready", m_rd_ready, 0);
      check("bp_p_rd_valid", p_rd_valid, 4'b0010);
      check("bp_rd_stall", p_rd_aready[1], 0);
      step;
    end
    p_rd_ready[1] = 1'b1;
    settle;
    check("bp_release_ready", m_rd_ready, 1);
    check("bp_release_data", p_rd_data[1*DW +: DW], 16'h4444);
    step;
    m_rd_valid = 1'b0;
    flag = 1'b0;
    for (int c = 0; c < 10 && !flag; c++) begin
      settle;
      if (m_rd_avalid && m_rd_aready && p_rd_aready[1]) begin
        check("full_resume_addr", m_rd_addr, 22'h0003FF);
        flag = 1'b1;
      end
      step;
    end
    p_rd_avalid[1] = 1'b0;
    check("full_resume", flag, 1);
    p_rd_ready = '1;
    for (int i = 0; i < 8; i++) expect_return(drain_ports[i], DW'(16'h5000 + i), "full_drain");

    // Stray data with an empty FIFO
    m_rd_valid = 1'b1;
    m_rd_data = 16'hDEAD;
    settle;
    check("stray_ready", m_rd_ready, 1);
    check("stray_p_valid", p_rd_valid, 0);
    check("stray_err_before", rd_tag_err, 0);
    step;
    m_rd_valid = 1'b0;
    settle;
    check("stray_err_set", rd_tag_err, 1);
    step; step; step;
    settle;
    check("stray_err_sticky", rd_tag_err, 1);
    pulse_reset;
    settle;
    check("stray_err_reset", rd_tag_err, 0);

    // Random traffic against the queue model
    clear_inputs;
    for (int i = 0; i < NPORT; i++) begin
      wpend[i] = 1'b0;
      rpend[i] = 1'b0;
    end
    ctrl_valid = 1'b0;
    ref_last = NPORT - 1;
    pset = '0;
    wset = '0;
    last_hs_c = -10;
    busy = 1'b1;
    for (int c = 0; c < 3 * NCYC && (c < NCYC || busy); c++) begin
      for (int j = 0; j < NPORT; j++) begin
        if (c < NCYC && !wpend[j] && $urandom_range(0, 3) == 0) begin
          wpend[j] = 1'b1;
          waddr[j] = AW'($urandom);
          wdata[j] = DW'($urandom);
        end
        if (c < NCYC && !rpend[j] && $urandom_range(0, 3) == 0) begin
          rpend[j] = 1'b1;
          raddr[j] = AW'($urandom);
        end
        p_wr_valid[j] = wpend[j];
        p_wr_addr[j*AW +: AW] = waddr[j];
        p_wr_data[j*DW +: DW] = wdata[j];
        p_rd_avalid[j] = rpend[j];
        p_rd_addr[j*AW +: AW] = raddr[j];
        p_rd_ready[j] = ($urandom_range(0, 3) != 0);
      end
      m_wr_ready  = ($urandom_range(0, 2) != 0);
      m_rd_aready = ($urandom_range(0, 2) != 0);
      if (!ctrl_valid && ctrl_q.size() > 0 && $urandom_range(0, 1) == 1) ctrl_valid = 1'b1;
      m_rd_valid = ctrl_valid;
      m_rd_data  = ctrl_valid ? ctrl_q[0] : '0;
      settle;

      exp_prv = (tagq.size() > 0 && m_rd_valid) ? (NPORT'(1) << tagq[0]) : '0;
      check("rnd_p_rd_valid", p_rd_valid, exp_prv);
      check("rnd_m_rd_ready", m_rd_ready, (tagq.size() > 0) ? p_rd_ready[tagq[0]] : 1'b1);
      if (m_rd_valid && m_rd_ready && tagq.size() > 0) begin
        k = tagq.pop_front();
        check("rnd_rd_data", p_rd_data[k*DW +: DW], exp_q[k].pop_front());
        void'(ctrl_q.pop_front());
        ctrl_valid = 1'b0;
      end

      hs_w = m_wr_valid && m_wr_ready;
      hs_r = m_rd_avalid && m_rd_aready;
      if (hs_w || hs_r) begin
        check("rnd_single_dir", hs_w && hs_r, 0);
        k = hs_w ? oh_idx(p_wr_ready) : oh_idx(p_rd_aready);
        check("rnd_onehot", k >= 0, 1);
        if (!HOLD) check("rnd_gap", (c - last_hs_c) >= 2, 1);
        last_hs_c = c;
        if (k >= 0) begin
          unfair = 1'b0;
          if (!(HOLD && k == ref_last)) begin
            for (int d = 1; d < NPORT; d++) begin
              if ((ref_last + d) % NPORT == k) break;
              if (pset[(ref_last + d) % NPORT]) unfair = 1'b1;
            end
            check("rnd_rr_order", unfair, 0);
            if (hs_r) check("rnd_wr_first", wset[k], 0);
          end
          if (hs_w) begin
            check("rnd_wr_addr", m_wr_addr, waddr[k]);
            check("rnd_wr_data", m_wr_data, wdata[k]);
            wpend[k] = 1'b0;
          end else begin
            check("rnd_rd_addr", m_rd_addr, raddr[k]);
            check("rnd_tag_limit", tagq.size() < TAG_DEPTH, 1);
            tagq.push_back(k);
            exp_q[k].push_back(memf(raddr[k]));
            ctrl_q.push_back(memf(raddr[k]));
            rpend[k] = 1'b0;
          end
          ref_last = k;
          for (int j = 0; j < NPORT; j++) begin
            wset[j] = wpend[j];
            pset[j] = wpend[j] | (rpend[j] & (tagq.size() < TAG_DEPTH));
          end
        end
      end
      busy = (tagq.size() > 0);
      for (int j = 0; j < NPORT; j++) if (wpend[j] || rpend[j]) busy = 1'b1;
      step;
    end
    check("rnd_drained", busy, 0);
    check("rnd_tag_err", rd_tag_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_mport_arb.md
# sdram_mport_arb

Multi-port front end for `sdram_top`. Arbitrates `NPORT` client write and read-address channels round-robin onto the single write and read channels of the SDRAM controller. Tags every accepted read with its port index in an in-order tag FIFO, and uses that FIFO to route returned read data back to the requesting client. Sits between the user logic and `sdram_top` inside `fpga_sdram_top` successors.

## Interface
- `NPORT`, 4: number of client ports, 2..8.
- `DW`, 16: data width.
- `AW`, 22: address width.
- `TAG_DEPTH`, 8: maximum outstanding reads; must be a power of 2.
- `HOLD_MAX`, 4: maximum consecutive beats per grant; used only with `SDRAM_ARB_HOLD_EN`.

Ports:
- `clk` in 1: single clock (133 MHz).
- `rst_n` in 1: asynchronous active-low reset.
- `sdram_init_done` in 1: controller initialisation complete.
- `p_wr_data` in NPORT*DW: per-port write data; port k is at `[k*DW +: DW]`.
- `p_wr_addr` in NPORT*AW: per-port write address.
- `p_wr_valid` in NPORT, `p_wr_ready` out NPORT: per-port write handshake.
- `p_rd_addr` in NPORT*AW: per-port read address.
- `p_rd_avalid` in NPORT, `p_rd_aready` out NPORT: per-port read-address handshake.
- `p_rd_data` out NPORT*DW: read data, broadcast to all ports.
- `p_rd_valid` out NPORT, `p_rd_ready` in NPORT: per-port read-data handshake.
- `m_wr_data` out DW, `m_wr_addr` out AW, `m_wr_valid` out 1, `m_wr_ready` in 1: to `sdram_top`.
- `m_rd_addr` out AW, `m_rd_avalid` out 1, `m_rd_aready` in 1: to `sdram_top`.
- `m_rd_data` in DW, `m_rd_valid` in 1, `m_rd_ready` out 1: from `sdram_top`.
- `rd_tag_err` out 1: sticky flag, set when read data arrives with no outstanding tag.

## Operation
- The FSM has three states: IDLE, ARB and XFER.
- IDLE: stays until `sdram_init_done`=1, then goes to ARB. `sdram_init_done` is sampled only in IDLE.
- ARB: request of port k is `p_wr_valid[k] | (p_rd_avalid[k] & !tag_full)`.
  - Search starts at `last+1` and wraps modulo NPORT.
  - The first requesting port is registered as `gnt_idx`.
  - Direction: write if `p_wr_valid[gnt_idx]` is set; otherwise read. Within a port, write wins.
  - Goes to XFER. With no request, stays in ARB.
- XFER: the granted port's channel for the granted direction is muxed to the `m_*` side. All other `p_*ready` are 0.
  - On handshake (`m_wr_valid&m_wr_ready` or `m_rd_avalid&m_rd_aready`): `last`←`gnt_idx`, then go to ARB.
  - A read handshake pushes `gnt_idx` into the tag FIFO.
  - If the granted valid drops before the handshake: no transfer, `last` is unchanged, return to ARB.
- Tag FIFO: `TAG_DEPTH` entries, each clog2(NPORT) bits wide.
  - Push on read-address handshake; pop on `m_rd_valid&m_rd_ready`.
  - Simultaneous push and pop keeps the count unchanged.
  - While the count equals `TAG_DEPTH`, read requests are masked out; writes are still granted.
- Return path: with the FIFO non-empty and head = h:
  - `p_rd_valid[h]`=`m_rd_valid`, other `p_rd_valid` bits are 0.
  - `m_rd_ready`=`p_rd_ready[h]`.
  - `p_rd_data` = `m_rd_data` replicated to every port.
- FIFO empty: `m_rd_ready`=1 so stray data drains. Any `m_rd_valid` in this state sets `rd_tag_err`, which clears only on reset.

## Timing
- Reset values:
  - State IDLE, `last`=NPORT-1 so port 0 has first priority, tag FIFO empty.
  - `m_wr_valid`, `m_rd_avalid`, all `p_wr_ready`, `p_rd_aready` and `p_rd_valid` are 0.
  - `m_rd_ready`=1 (FIFO empty), `rd_tag_err`=0.
  - `m_*` data and address outputs are 0.
- Reset is asynchronous and acts mid-transfer. It flushes the tag FIFO, and reads already issued to the controller are lost.
- Request to master valid: a request in cycle n while in ARB gives `m_*valid`=1 in cycle n+1. The master path is combinational from the registered grant.
- Throughput without hold: one beat per 2 cycles.
- Return path is purely combinational, zero added latency.
- Valid/ready rule: a transfer occurs on the cycle both are 1. Upstream valids must not drop before ready.

## Configuration
- `SDRAM_ARB_HOLD_EN` defined:
  - After a handshake in XFER, the grant is kept (no ARB cycle) if the same port still requests the same direction and the beat count is below `HOLD_MAX`.
  - A read hold also requires `!tag_full`.
  - The beat counter resets on every new grant.
  - Result: back-to-back beats at one per cycle, up to `HOLD_MAX` per grant.
- Undefined: every handshake returns to ARB, and `HOLD_MAX` is ignored.

## Test plan
- Init gating: `sdram_init_done`=0 and port 0 writes `addr=0x000010, data=0xA5A5` → no `m_wr_valid`. After init rises, the write appears 2 cycles later with the same addr and data.
- Round-robin: all 4 ports hold write valid with `m_wr_ready`=1 → grant order 0,1,2,3,0. Without hold, each beat is 2 cycles apart.
- Read routing: ports 2, 0, 3 issue reads in that order. Controller returns 0x1111, 0x2222, 0x3333 → `p_rd_valid[2]`, `[0]`, `[3]` in that order with matching data.
- Tag full: 8 reads accepted and none returned; a 9th read on port 1 stalls (`p_rd_aready`=0) while a port 3 write is still granted. One return makes the port 1 read issue.
- Backpressure: head port 1 holds `p_rd_ready`=0 for 5 cycles → `m_rd_ready`=0 for those cycles and no data is lost. Stray `m_rd_valid` with the FIFO empty → `rd_tag_err`=1 and stays set.
- `SDRAM_ARB_HOLD_EN`, `HOLD_MAX`=4: port 0 streams 6 writes → 4 beats on consecutive cycles, then ARB. Port 0 regains the grant only after the other requesters are served.
